// File: rtl/mac_drain_pkg.sv
// Shared constants and state type for the mac_drain serializer.
package mac_drain_pkg;

   localparam int NUM_CH               = 16;
   localparam int CH_IDX_WIDTH         = 4;
   localparam int DEFAULT_OUTPUT_WIDTH = 16;

   localparam logic [CH_IDX_WIDTH-1:0] LAST_CH = CH_IDX_WIDTH'(NUM_CH - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

endpackage

// File: rtl/mac_drain.sv
// Captures 16 parallel MAC results and drains them one channel per beat over a
// valid/ready stream. Define MAC_DRAIN_RELU_EN to clamp negative results to 0 at capture.
module mac_drain
   import mac_drain_pkg::*;
#(
   parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
   input  logic                           clk,
   input  logic                           arst_in,
   input  logic                           capture,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out0,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out1,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out2,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out3,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out4,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out5,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out6,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out7,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out8,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out9,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out10,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out11,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out12,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out13,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out14,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out15,
   output logic signed [OUTPUT_WIDTH-1:0] data_out,
   output logic                           data_valid,
   input  logic                           data_ready,
   output logic [CH_IDX_WIDTH-1:0]        ch_idx,
   output logic                           last,
   output logic                           busy,
   output logic                           overrun
);

   state_t                         state;
   logic signed [OUTPUT_WIDTH-1:0] mac_in [NUM_CH];
   logic signed [OUTPUT_WIDTH-1:0] hold   [NUM_CH];
   logic [CH_IDX_WIDTH-1:0]        next_ch;
   logic                           xfer;
   logic                           load;

   function automatic logic signed [OUTPUT_WIDTH-1:0] relu(input logic signed [OUTPUT_WIDTH-1:0] v);
`ifdef MAC_DRAIN_RELU_EN
      return v[OUTPUT_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign mac_in = '{mac_out0,  mac_out1,  mac_out2,  mac_out3,
                     mac_out4,  mac_out5,  mac_out6,  mac_out7,
                     mac_out8,  mac_out9,  mac_out10, mac_out11,
                     mac_out12, mac_out13, mac_out14, mac_out15};

   // A capture is only taken when idle or when it lands exactly on the final
   // transfer, so a back-to-back frame streams with no bubble.
   assign xfer    = (state == STREAM) && data_ready;
   assign load    = capture && ((state == IDLE) || (xfer && (ch_idx == LAST_CH)));
   assign next_ch = ch_idx + 1'b1;

   assign data_valid = (state == STREAM);
   assign busy       = (state == STREAM);
   assign last       = data_valid && (ch_idx == LAST_CH);

   // NOTE: the holding bank is cleared by reset because the reset contract
   // requires it; it is small enough to live in flops rather than a RAM.
   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state    <= IDLE;
         ch_idx   <= '0;
         data_out <= '0;
         overrun  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
      end else begin
         if (load) begin
            for (int i = 0; i < NUM_CH; i++) hold[i] <= relu(mac_in[i]);
            data_out <= relu(mac_in[0]);
            ch_idx   <= '0;
            state    <= STREAM;
         end else if (xfer) begin
            if (ch_idx == LAST_CH) begin
               state <= IDLE;
            end else begin
               ch_idx   <= next_ch;
               data_out <= hold[next_ch];
            end
         end

         if (capture && (state == STREAM) && !load) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_drain.sv
// Self-checking bench for mac_drain: scoreboard of expected beats plus a
// table-driven frame; honours MAC_DRAIN_RELU_EN when computing expectations.
module tb_mac_drain;
   import mac_drain_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic signed [W-1:0]     data;
      logic [CH_IDX_WIDTH-1:0] ch;
      logic                    last;
   } beat_t;

   typedef struct {
      logic signed [W-1:0] in;
      logic signed [W-1:0] exp;
   } vec_t;

   logic                    clk = 1'b0;
   logic                    arst_in;
   logic                    capture;
   logic                    data_ready;
   logic signed [W-1:0]     mac [NUM_CH];
   logic signed [W-1:0]     data_out;
   logic                    data_valid;
   logic [CH_IDX_WIDTH-1:0] ch_idx;
   logic                    last;
   logic                    busy;
   logic                    overrun;

   logic signed [W-1:0] exp_set [NUM_CH];
   vec_t                tbl [NUM_CH];
   beat_t               sb [$];
   int                  checks = 0;
   int                  errors = 0;
   int                  beats_seen = 0;

   always #5 clk = ~clk;

   mac_drain #(.OUTPUT_WIDTH(W)) dut (
      .clk       (clk),
      .arst_in   (arst_in),
      .capture   (capture),
      .mac_out0  (mac[0]),
      .mac_out1  (mac[1]),
      .mac_out2  (mac[2]),
      .mac_out3  (mac[3]),
      .mac_out4  (mac[4]),
      .mac_out5  (mac[5]),
      .mac_out6  (mac[6]),
      .mac_out7  (mac[7]),
      .mac_out8  (mac[8]),
      .mac_out9  (mac[9]),
      .mac_out10 (mac[10]),
      .mac_out11 (mac[11]),
      .mac_out12 (mac[12]),
      .mac_out13 (mac[13]),
      .mac_out14 (mac[14]),
      .mac_out15 (mac[15]),
      .data_out  (data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .ch_idx    (ch_idx),
      .last      (last),
      .busy      (busy),
      .overrun   (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic signed [W-1:0] relu_exp(input logic signed [W-1:0] v);
`ifdef MAC_DRAIN_RELU_EN
      return (v < 0) ? W'(0) : v;
`else
      return v;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input int base);
      for (int i = 0; i < NUM_CH; i++) begin
         mac[i]     = W'(base + i);
         exp_set[i] = relu_exp(mac[i]);
      end
   endtask

   // One clock: drive inputs, score any beat that transfers on the coming edge,
   // and optionally queue the frame this capture is expected to load.
   task automatic cycle(input logic rdy, input logic cap, input logic accept);
      beat_t b;
      data_ready = rdy;
      capture    = cap;
      if (data_valid && rdy) begin
         beats_seen++;
         if (sb.size() == 0) begin
            check("unexpected_beat", 32'(data_valid), 0);
         end else begin
            b = sb.pop_front();
            check("beat_data", data_out, b.data);
            check("beat_ch",   ch_idx,   b.ch);
            check("beat_last", last,     b.last);
         end
      end else if (data_valid && sb.size() != 0) begin
         check("stall_data", data_out, sb[0].data);
         check("stall_ch",   ch_idx,   sb[0].ch);
         check("stall_last", last,     sb[0].last);
      end
      if (accept)
         for (int i = 0; i < NUM_CH; i++)
            sb.push_back('{exp_set[i], CH_IDX_WIDTH'(i), (i == NUM_CH - 1)});
      tick();
   endtask

   task automatic run_beats(input int n, input bit toggle, output int cycles);
      int  target = beats_seen + n;
      int  budget = 4 * n + 10;
      logic r = 1'b1;
      cycles = 0;
      while (beats_seen < target && budget > 0) begin
         cycle(toggle ? r : 1'b1, 1'b0, 1'b0);
         r = ~r;
         budget--;
         cycles++;
      end
      if (beats_seen < target) check("beat_timeout", beats_seen, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      arst_in    = 1'b1;
      capture    = 1'b0;
      data_ready = 1'b0;
      set_frame(0);

      tbl = '{'{16'sd1,     16'sd1},     '{16'sd7,     16'sd7},
              '{16'sd0,     16'sd0},     '{-16'sd5,    16'sd0},
              '{16'sh7FFF,  16'sh7FFF},  '{16'sh8000,  16'sd0},
              '{-16'sd1,    16'sd0},     '{16'sd100,   16'sd100},
              '{16'sh1234,  16'sh1234},  '{-16'sd300,  16'sd0},
              '{16'sd2,     16'sd2},     '{16'sd3,     16'sd3},
              '{16'sd4,     16'sd4},     '{16'sh4000,  16'sh4000},
              '{-16'sd2,    16'sd0},     '{16'sd15,    16'sd15}};
`ifndef MAC_DRAIN_RELU_EN
      for (int i = 0; i < NUM_CH; i++) tbl[i].exp = tbl[i].in;
`endif

      // Reset state
      tick();
      tick();
      check("rst_valid",   data_valid, 0);
      check("rst_busy",    busy,       0);
      check("rst_last",    last,       0);
      check("rst_overrun", overrun,    0);
      check("rst_ch_idx",  ch_idx,     0);
      check("rst_data",    data_out,   0);
      #2 arst_in = 1'b0;
      tick();

      // Full-rate frame: 16 consecutive beats
      set_frame(1);
      cycle(1'b1, 1'b1, 1'b1);
      check("lat_valid", data_valid, 1);
      check("lat_busy",  busy,       1);
      run_beats(16, 1'b0, cyc);
      check("fullrate_cycles", cyc, 16);
      check("end_valid", data_valid, 0);
      check("end_busy",  busy,       0);
      check("end_last",  last,       0);

      // Same frame with ready toggling 1,0,1,0...
      cycle(1'b1, 1'b1, 1'b1);
      run_beats(16, 1'b1, cyc);
      check("toggle_cycles", cyc, 31);
      check("toggle_idle", busy, 0);

      // Table-driven frame, including the negative channel-3 value
      for (int i = 0; i < NUM_CH; i++) begin
         mac[i]     = tbl[i].in;
         exp_set[i] = tbl[i].exp;
      end
      cycle(1'b1, 1'b1, 1'b1);
      run_beats(3, 1'b0, cyc);
      check("relu_ch3_idx",  ch_idx,   3);
      check("relu_ch3_data", data_out, tbl[3].exp);
      run_beats(13, 1'b0, cyc);
      check("tbl_idle", data_valid, 0);

      // Capture mid-frame is dropped and flags overrun
      set_frame(1);
      cycle(1'b1, 1'b1, 1'b1);
      run_beats(5, 1'b0, cyc);
      for (int i = 0; i < NUM_CH; i++) mac[i] = W'(500 + i);
      cycle(1'b1, 1'b1, 1'b0);
      check("ovr_set", overrun, 1);
      run_beats(10, 1'b0, cyc);
      check("ovr_frame_done", busy, 0);
      set_frame(40);
      cycle(1'b1, 1'b1, 1'b1);
      run_beats(16, 1'b0, cyc);
      check("ovr_sticky", overrun, 1);

      // Asynchronous reset mid-frame at beat 7
      set_frame(1);
      cycle(1'b1, 1'b1, 1'b1);
      run_beats(7, 1'b0, cyc);
      #2 arst_in = 1'b1;
      #1;
      check("arst_valid",   data_valid, 0);
      check("arst_busy",    busy,       0);
      check("arst_last",    last,       0);
      check("arst_overrun", overrun,    0);
      check("arst_ch_idx",  ch_idx,     0);
      check("arst_data",    data_out,   0);
      sb.delete();
      @(posedge clk);
      #2 arst_in = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
      check("post_rst_quiet", data_valid, 0);

      // Capture coinciding with the channel-15 transfer is accepted
      set_frame(1);
      cycle(1'b1, 1'b1, 1'b1);
      run_beats(15, 1'b0, cyc);
      check("b2b_at_last", last, 1);
      set_frame(100);
      cycle(1'b1, 1'b1, 1'b1);
      check("b2b_valid",   data_valid, 1);
      check("b2b_ch_idx",  ch_idx,     0);
      check("b2b_data",    data_out,   100);
      check("b2b_overrun", overrun,    0);
      run_beats(16, 1'b0, cyc);
      check("b2b_idle",    busy,       0);
      check("sb_empty",    sb.size(),  0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
